instr_fetch: RTL and testbench

Instruction fetch stage of the MIPS pipeline. Consumes the program counter value and produces the PC register's next value (`o_next_pc`, wired to the PC's `i_mux`) plus a one-cycle update enable. Drives a request/valid handshake to instruction memory and holds the IF/ID pipeline register. Handles decode stalls, pipeline flushes and branch/jump redirects.

---
 rtl/instr_fetch.sv | 157 +++++++++++++++
 tb/tb_instr_fetch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the instruction-memory handshake, computes the next PC,
// applies pending branch/jump redirects at the response and holds the IF/ID register.
module instr_fetch #(
   parameter int len = 32
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic [len-1:0] i_pc,
   output logic [len-1:0] o_next_pc,
   output logic           o_pc_en,
   output logic           o_imem_req,
   output logic [len-1:0] o_imem_addr,
   input  logic           i_imem_valid,
   input  logic [len-1:0] i_imem_data,
   input  logic           i_stall,
   input  logic           i_flush,
   input  logic           i_branch_taken,
   input  logic [len-1:0] i_branch_target,
   input  logic           i_jump,
   input  logic [len-1:0] i_jump_target,
   output logic [len-1:0] o_instr,
   output logic [len-1:0] o_pc_plus4,
   output logic           o_valid
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t         state_q, state_d;
   logic           pend_q, pend_d;
   logic [len-1:0] pend_tgt_q, pend_tgt_d;
   logic [len-1:0] hold_instr_q, hold_instr_d;
   logic [len-1:0] hold_pc4_q, hold_pc4_d;
   logic [len-1:0] instr_q, instr_d;
   logic [len-1:0] pc4_q, pc4_d;
   logic           valid_q, valid_d;

   logic           redir_now, redir_any;
   logic [len-1:0] tgt_now, redir_tgt, pc_plus4;
   logic           req_c, pc_en_c;
   logic           ld_mem, ld_hold, bubble;

   assign pc_plus4  = i_pc + len'(4);
   assign redir_now = i_jump | i_branch_taken;
   assign tgt_now   = i_jump ? i_jump_target : i_branch_target;
   // A redirect arriving this cycle is newer than anything pending, so it wins.
   assign redir_any = redir_now | pend_q;
   assign redir_tgt = redir_now ? tgt_now : pend_tgt_q;

   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      pend_tgt_d   = pend_tgt_q;
      hold_instr_d = hold_instr_q;
      hold_pc4_d   = hold_pc4_q;
      req_c        = 1'b0;
      pc_en_c      = 1'b0;
      o_next_pc    = pc_plus4;
      ld_mem       = 1'b0;
      ld_hold      = 1'b0;
      bubble       = 1'b0;

      if (redir_now) begin
         pend_d     = 1'b1;
         pend_tgt_d = tgt_now;
      end

      case (state_q)
         FETCH: begin
            req_c = 1'b1;
            if (i_imem_valid) begin
               pc_en_c = 1'b1;
               if (redir_any) begin
                  o_next_pc  = redir_tgt;
                  pend_d     = 1'b0;
                  pend_tgt_d = '0;
                  bubble     = ~i_stall;
               end else if (!i_stall) begin
                  ld_mem = 1'b1;
               end else begin
                  // PC still advances; the word waits in the hold buffer until decode frees up.
                  hold_instr_d = i_imem_data;
                  hold_pc4_d   = pc_plus4;
                  state_d      = HOLD;
               end
            end else if (!i_stall) begin
               bubble = 1'b1;
            end
         end
         HOLD: begin
            if (redir_any) begin
               pc_en_c      = 1'b1;
               o_next_pc    = redir_tgt;
               pend_d       = 1'b0;
               pend_tgt_d   = '0;
               hold_instr_d = '0;
               hold_pc4_d   = '0;
               bubble       = ~i_stall;
               state_d      = FETCH;
            end else if (!i_stall) begin
               ld_hold = 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (i_flush || bubble) begin
         instr_d = '0;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (ld_mem) begin
         instr_d = i_imem_data;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
      end else if (ld_hold) begin
         instr_d = hold_instr_q;
         pc4_d   = hold_pc4_q;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= FETCH;
         pend_q       <= 1'b0;
         pend_tgt_q   <= '0;
         hold_instr_q <= '0;
         hold_pc4_q   <= '0;
         instr_q      <= '0;
         pc4_q        <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         pend_tgt_q   <= pend_tgt_d;
         hold_instr_q <= hold_instr_d;
         hold_pc4_q   <= hold_pc4_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
      end
   end

   // Handshake outputs are forced low for the whole time reset is held.
   assign o_imem_req  = req_c & i_rst;
   assign o_pc_en     = pc_en_c & i_rst;
   assign o_imem_addr = i_pc;
   assign o_instr     = instr_q;
   assign o_pc_plus4  = pc4_q;
   assign o_valid     = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; the bench plays both the PC register and instruction memory.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        pc_en;
   logic        req;
   logic [31:0] addr;
   logic        mvalid;
   logic [31:0] mdata;
   logic        stall, flush, br, jmp;
   logic [31:0] br_tgt, jmp_tgt;
   logic [31:0] instr, pc4;
   logic        valid;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   instr_fetch #(.len(32)) dut (
      .i_clk(clk), .i_rst(rst_n), .i_pc(pc), .o_next_pc(next_pc), .o_pc_en(pc_en),
      .o_imem_req(req), .o_imem_addr(addr), .i_imem_valid(mvalid), .i_imem_data(mdata),
      .i_stall(stall), .i_flush(flush), .i_branch_taken(br), .i_branch_target(br_tgt),
      .i_jump(jmp), .i_jump_target(jmp_tgt), .o_instr(instr), .o_pc_plus4(pc4), .o_valid(valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pc = 32'h0; mvalid = 1'b1; mdata = 32'hFFFF_FFFF;
      stall = 0; flush = 0; br = 0; jmp = 0; br_tgt = 0; jmp_tgt = 0;
      #2;
      ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", valid); end
      ncmp++; if (instr !== 32'h0) begin nerr++; $display("FAIL rst_instr got %h want 0", instr); end
      ncmp++; if (pc4 !== 32'h0) begin nerr++; $display("FAIL rst_pc4 got %h want 0", pc4); end
      ncmp++; if (pc_en !== 1'b0) begin nerr++; $display("FAIL rst_pc_en got %b want 0", pc_en); end
      ncmp++; if (req !== 1'b0) begin nerr++; $display("FAIL rst_req got %b want 0", req); end
      tick(); tick();
      rst_n = 1'b1; mvalid = 1'b0;
      #1;
      ncmp++; if (req !== 1'b1) begin nerr++; $display("FAIL rst_rel_req got %b want 1", req); end
      ncmp++; if (addr !== 32'h0) begin nerr++; $display("FAIL rst_rel_addr got %h want 0", addr); end
   endtask

   task automatic test_seq_fetch();
      #1;
      ncmp++; if (pc_en !== 1'b0) begin nerr++; $display("FAIL seq_wait_pc_en got %b want 0", pc_en); end
      tick();
      mvalid = 1'b1; mdata = 32'h2008_0005;
      #1;
      ncmp++; if (pc_en !== 1'b1) begin nerr++; $display("FAIL seq_pc_en got %b want 1", pc_en); end
      ncmp++; if (next_pc !== 32'h4) begin nerr++; $display("FAIL seq_next_pc got %h want 00000004", next_pc); end
      tick();
      pc = 32'h4; mvalid = 1'b0;
      #1;
      ncmp++; if (instr !== 32'h2008_0005) begin nerr++; $display("FAIL seq_instr got %h want 20080005", instr); end
      ncmp++; if (pc4 !== 32'h4) begin nerr++; $display("FAIL seq_pc4 got %h want 00000004", pc4); end
      ncmp++; if (valid !== 1'b1) begin nerr++; $display("FAIL seq_valid got %b want 1", valid); end
   endtask

   task automatic test_stall_at_response();
      mvalid = 1'b1; mdata = 32'h8C09_0000; stall = 1'b1;
      #1;
      ncmp++; if (pc_en !== 1'b1) begin nerr++; $display("FAIL stall_pc_en got %b want 1", pc_en); end
      ncmp++; if (next_pc !== 32'h8) begin nerr++; $display("FAIL stall_next_pc got %h want 00000008", next_pc); end
      tick();
      pc = 32'h8; mvalid = 1'b0;
      #1;
      ncmp++; if (instr !== 32'h2008_0005) begin nerr++; $display("FAIL stall_ifid_hold got %h want 20080005", instr); end
      ncmp++; if (req !== 1'b0) begin nerr++; $display("FAIL stall_req got %b want 0", req); end
      tick(); tick();
      ncmp++; if (valid !== 1'b1) begin nerr++; $display("FAIL stall_valid_hold got %b want 1", valid); end
      stall = 1'b0;
      tick();
      ncmp++; if (instr !== 32'h8C09_0000) begin nerr++; $display("FAIL unstall_instr got %h want 8c090000", instr); end
      ncmp++; if (pc4 !== 32'h8) begin nerr++; $display("FAIL unstall_pc4 got %h want 00000008", pc4); end
      ncmp++; if (req !== 1'b1) begin nerr++; $display("FAIL unstall_req got %b want 1", req); end
      ncmp++; if (addr !== 32'h8) begin nerr++; $display("FAIL unstall_addr got %h want 00000008", addr); end
   endtask

   task automatic test_reset_mid_fetch();
      mvalid = 1'b1; mdata = 32'h1234_5678; rst_n = 1'b0;
      #1;
      ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_valid got %b want 0", valid); end
      ncmp++; if (instr !== 32'h0) begin nerr++; $display("FAIL mid_rst_instr got %h want 0", instr); end
      ncmp++; if (pc_en !== 1'b0) begin nerr++; $display("FAIL mid_rst_pc_en got %b want 0", pc_en); end
      tick(); tick();
      rst_n = 1'b1; mvalid = 1'b0;
      #1;
      ncmp++; if (req !== 1'b1) begin nerr++; $display("FAIL mid_rel_req got %b want 1", req); end
      ncmp++; if (addr !== 32'h8) begin nerr++; $display("FAIL mid_rel_addr got %h want 00000008", addr); end
   endtask

   task automatic test_branch_during_wait();
      br = 1'b1; br_tgt = 32'h40;
      #1;
      ncmp++; if (pc_en !== 1'b0) begin nerr++; $display("FAIL br_pulse_pc_en got %b want 0", pc_en); end
      tick();
      br = 1'b0; br_tgt = 32'h999;
      tick(); tick();
      mvalid = 1'b1; mdata = 32'hDEAD_BEEF;
      #1;
      ncmp++; if (pc_en !== 1'b1) begin nerr++; $display("FAIL br_pc_en got %b want 1", pc_en); end
      ncmp++; if (next_pc !== 32'h40) begin nerr++; $display("FAIL br_next_pc got %h want 00000040", next_pc); end
      tick();
      pc = 32'h40; mvalid = 1'b0;
      #1;
      ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL br_valid got %b want 0", valid); end
      ncmp++; if (instr !== 32'h0) begin nerr++; $display("FAIL br_instr got %h want 0", instr); end
      mvalid = 1'b1; mdata = 32'h1111_1111;
      #1;
      ncmp++; if (next_pc !== 32'h44) begin nerr++; $display("FAIL br_cleared_next_pc got %h want 00000044", next_pc); end
      tick();
      pc = 32'h44; mvalid = 1'b0;
      #1;
      ncmp++; if (instr !== 32'h1111_1111) begin nerr++; $display("FAIL br_target_instr got %h want 11111111", instr); end
      ncmp++; if (pc4 !== 32'h44) begin nerr++; $display("FAIL br_target_pc4 got %h want 00000044", pc4); end
   endtask

   task automatic test_simultaneous_redirect();
      jmp = 1'b1; jmp_tgt = 32'h100; br = 1'b1; br_tgt = 32'h80;
      tick();
      jmp = 1'b0; br = 1'b0;
      mvalid = 1'b1; mdata = 32'h0BAD_0BAD;
      #1;
      ncmp++; if (pc_en !== 1'b1) begin nerr++; $display("FAIL sim_pc_en got %b want 1", pc_en); end
      ncmp++; if (next_pc !== 32'h100) begin nerr++; $display("FAIL sim_next_pc got %h want 00000100", next_pc); end
      tick();
      pc = 32'h100; mvalid = 1'b0;
      #1;
      ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL sim_valid got %b want 0", valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w, exp_pc;
      for (int i = 0; i < 3; i++) begin
         w = 32'hA000_0000 + 32'(i);
         exp_pc = 32'h104 + 32'(4 * i);
         mvalid = 1'b1; mdata = w;
         #1;
         ncmp++; if (next_pc !== exp_pc || pc_en !== 1'b1) begin nerr++; $display("FAIL b2b_next_pc[%0d] got %h en %b want %h en 1", i, next_pc, pc_en, exp_pc); end
         tick();
         pc = exp_pc;
         ncmp++; if (instr !== w || pc4 !== exp_pc || valid !== 1'b1) begin nerr++; $display("FAIL b2b_ifid[%0d] got %h/%h/%b want %h/%h/1", i, instr, pc4, valid, w, exp_pc); end
      end
      mvalid = 1'b0;
   endtask

   task automatic test_flush_in_hold();
      mvalid = 1'b1; mdata = 32'h5555_5555; stall = 1'b1;
      tick();
      pc = 32'h110; mvalid = 1'b0; flush = 1'b1;
      tick();
      ncmp++; if (valid !== 1'b0 || instr !== 32'h0) begin nerr++; $display("FAIL hold_flush got %h/%b want 00000000/0", instr, valid); end
      flush = 1'b0; stall = 1'b0;
      tick();
      ncmp++; if (instr !== 32'h5555_5555) begin nerr++; $display("FAIL hold_kept_instr got %h want 55555555", instr); end
      ncmp++; if (pc4 !== 32'h110 || valid !== 1'b1) begin nerr++; $display("FAIL hold_kept_pc4 got %h/%b want 00000110/1", pc4, valid); end
   endtask

   task automatic test_flush_stall_wrap();
      flush = 1'b1; stall = 1'b1;
      tick();
      ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL fl_valid got %b want 0", valid); end
      ncmp++; if (instr !== 32'h0) begin nerr++; $display("FAIL fl_instr got %h want 0", instr); end
      flush = 1'b0; stall = 1'b0;
      pc = 32'hFFFF_FFFC; mvalid = 1'b1; mdata = 32'h3333_3333;
      #1;
      ncmp++; if (next_pc !== 32'h0 || pc_en !== 1'b1) begin nerr++; $display("FAIL wrap_next_pc got %h en %b want 00000000 en 1", next_pc, pc_en); end
      tick();
      pc = 32'h0; mvalid = 1'b0;
      ncmp++; if (pc4 !== 32'h0) begin nerr++; $display("FAIL wrap_pc4 got %h want 0", pc4); end
      ncmp++; if (instr !== 32'h3333_3333 || valid !== 1'b1) begin nerr++; $display("FAIL wrap_instr got %h/%b want 33333333/1", instr, valid); end
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_stall_at_response();
      test_reset_mid_fetch();
      test_branch_during_wait();
      test_simultaneous_redirect();
      test_back_to_back();
      test_flush_in_hold();
      test_flush_stall_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
